regread_arbiter: RTL and testbench



---
 rtl/regread_arbiter.sv | 167 ++++++++++++++++
 tb/tb_regread_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/regread_arbiter.sv
// Round-robin arbiter sharing one 32-entry register read port among NREQ requesters.
// Stage 1 accepts a winner and registers its address; stage 2 reads the mux and acks.

module regread_mux32 #(
    parameter int N = 32
) (
    input  logic [32*N-1:0] regs,
    input  logic [4:0]      sel,
    output logic [N-1:0]    dout
);

    logic [N-1:0] words [32];

    always_comb begin
        for (int k = 0; k < 32; k++) begin
            words[k] = regs[k*N +: N];
        end
        dout = words[sel];
    end

endmodule

module regread_arbiter #(
    parameter int          N       = 32,
    parameter int          NREQ    = 4,
    parameter int unsigned ZERO_R0 = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*5-1:0]        addr,
    input  logic [32*N-1:0]          regs,
    output logic [4:0]               sel,
    output logic [N-1:0]             rd_data,
    output logic [NREQ-1:0]          ack,
    output logic [$clog2(NREQ)-1:0]  ack_id,
    output logic                     busy
);

    localparam int IDW = $clog2(NREQ);

    logic [4:0]      sel_q,     sel_d;
    logic [IDW-1:0]  owner_q,   owner_d;
    logic            v1_q,      v1_d;
    logic [NREQ-1:0] pending_q, pending_d;
    logic [IDW-1:0]  ptr_q,     ptr_d;
    logic [N-1:0]    rd_data_q, rd_data_d;
    logic [NREQ-1:0] ack_q,     ack_d;
    logic [IDW-1:0]  ack_id_q,  ack_id_d;

    logic [NREQ-1:0] eligible;
    logic            grant_valid;
    logic [IDW-1:0]  grant_id;
    logic [4:0]      grant_addr;
    logic [N-1:0]    mux_word;
    logic [N-1:0]    read_word;

    regread_mux32 #(.N(N)) u_mux32 (
        .regs (regs),
        .sel  (sel_q),
        .dout (mux_word)
    );

    // A requester still showing ack this cycle must not be re-accepted on the same held req.
    always_comb begin
        int idx;
        idx         = 0;
        eligible    = req & ~pending_q & ~ack_q;
        grant_valid = 1'b0;
        grant_id    = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!grant_valid && eligible[idx]) begin
                grant_valid = 1'b1;
                grant_id    = IDW'(idx);
            end
        end
    end

    always_comb begin
        grant_addr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_id == IDW'(i)) begin
                grant_addr = addr[i*5 +: 5];
            end
        end
    end

    always_comb begin
        read_word = mux_word;
        if (ZERO_R0 != 0 && sel_q == 5'd0) begin
            read_word = '0;
        end
    end

    always_comb begin
        sel_d     = sel_q;
        owner_d   = owner_q;
        v1_d      = grant_valid;
        pending_d = pending_q;
        ptr_d     = ptr_q;
        rd_data_d = rd_data_q;
        ack_d     = '0;
        ack_id_d  = ack_id_q;

        if (v1_q) begin
            rd_data_d = read_word;
            ack_id_d  = owner_q;
            for (int i = 0; i < NREQ; i++) begin
                if (owner_q == IDW'(i)) begin
                    ack_d[i]     = 1'b1;
                    pending_d[i] = 1'b0;
                end
            end
        end

        // The owner being acked is still pending, so it can never be the new winner here.
        if (grant_valid) begin
            sel_d   = grant_addr;
            owner_d = grant_id;
            if (grant_id == IDW'(NREQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_id + IDW'(1);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (grant_id == IDW'(i)) begin
                    pending_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q     <= '0;
            owner_q   <= '0;
            v1_q      <= 1'b0;
            pending_q <= '0;
            ptr_q     <= '0;
            rd_data_q <= '0;
            ack_q     <= '0;
            ack_id_q  <= '0;
        end else begin
            sel_q     <= sel_d;
            owner_q   <= owner_d;
            v1_q      <= v1_d;
            pending_q <= pending_d;
            ptr_q     <= ptr_d;
            rd_data_q <= rd_data_d;
            ack_q     <= ack_d;
            ack_id_q  <= ack_id_d;
        end
    end

    assign sel     = sel_q;
    assign rd_data = rd_data_q;
    assign ack     = ack_q;
    assign ack_id  = ack_id_q;
    assign busy    = v1_q;

    ack_onehot_a: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(ack_q));

endmodule

// File: tb/tb_regread_arbiter.sv
// Directed bench for regread_arbiter: two instances differing only in ZERO_R0,
// checked against hand-derived acks, ids, selects and read data.

module tb_regread_arbiter;

    logic             clk;
    logic             rst_n;
    logic [3:0]       req;
    logic [19:0]      addr;
    logic [1023:0]    regs;
    logic [31:0]      regArr [32];

    logic [4:0]       sel,     sel0;
    logic [31:0]      rdData,  rdData0;
    logic [3:0]       ack,     ack0;
    logic [1:0]       ackId,   ackId0;
    logic             busy,    busy0;

    int assertCount = 0;
    int failCount   = 0;

    regread_arbiter #(.N(32), .NREQ(4), .ZERO_R0(1)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .addr    (addr),
        .regs    (regs),
        .sel     (sel),
        .rd_data (rdData),
        .ack     (ack),
        .ack_id  (ackId),
        .busy    (busy)
    );

    regread_arbiter #(.N(32), .NREQ(4), .ZERO_R0(0)) dut0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .addr    (addr),
        .regs    (regs),
        .sel     (sel0),
        .rd_data (rdData0),
        .ack     (ack0),
        .ack_id  (ackId0),
        .busy    (busy0)
    );

    always_comb begin
        for (int k = 0; k < 32; k++) begin
            regs[k*32 +: 32] = regArr[k];
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int id, input logic r, input logic [4:0] a);
        req[id]          = r;
        addr[id*5 +: 5]  = a;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        addr  = '0;
        for (int k = 0; k < 32; k++) begin
            regArr[k] = k * 32'h11;
        end

        // Reset state and single read
        #22;
        checkOutput("rst_sel",    32'(sel),    32'h0);
        checkOutput("rst_rdata",  rdData,      32'h0);
        checkOutput("rst_ack",    32'(ack),    32'h0);
        checkOutput("rst_ackid",  32'(ackId),  32'h0);
        checkOutput("rst_busy",   32'(busy),   32'h0);
        rst_n = 1'b1;
        stepClock();
        applyStimulus(2, 1'b1, 5'd5);
        stepClock();
        checkOutput("t1_sel",     32'(sel),    32'd5);
        checkOutput("t1_busy",    32'(busy),   32'd1);
        checkOutput("t1_noack",   32'(ack),    32'h0);
        stepClock();
        checkOutput("t1_ack",     32'(ack),    32'b0100);
        checkOutput("t1_ackid",   32'(ackId),  32'd2);
        checkOutput("t1_rdata",   rdData,      32'h55);
        stepClock();
        checkOutput("t1_ackdrop", 32'(ack),    32'h0);
        checkOutput("t1_idle",    32'(busy),   32'h0);
        applyStimulus(2, 1'b0, 5'd0);

        // Register zero, both ZERO_R0 settings
        regArr[0] = 32'hDEADBEEF;
        applyStimulus(0, 1'b1, 5'd0);
        stepClock();
        stepClock();
        checkOutput("t2_ack",     32'(ack),    32'b0001);
        checkOutput("t2_zero",    rdData,      32'h0);
        checkOutput("t2_nozero",  rdData0,     32'hDEADBEEF);
        stepClock();
        applyStimulus(0, 1'b0, 5'd0);

        // Late data capture: regs sampled at the stage-2 edge
        regArr[7] = 32'h1;
        applyStimulus(1, 1'b1, 5'd7);
        stepClock();
        regArr[7] = 32'h2;
        stepClock();
        checkOutput("t5_ack",     32'(ack),    32'b0010);
        checkOutput("t5_ackid",   32'(ackId),  32'd1);
        checkOutput("t5_rdata",   rdData,      32'h2);
        stepClock();
        applyStimulus(1, 1'b0, 5'd0);

        // Reset mid-flight: ptr is 2 here, so requester 2 wins and ptr moves to 3
        applyStimulus(2, 1'b1, 5'd4);
        stepClock();
        checkOutput("t6_sel",     32'(sel),    32'd4);
        checkOutput("t6_busy",    32'(busy),   32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_ack",   32'(ack),  32'h0);
        checkOutput("t6_rst_busy",  32'(busy), 32'h0);
        checkOutput("t6_rst_sel",   32'(sel),  32'h0);
        checkOutput("t6_rst_rdata", rdData,    32'h0);
        applyStimulus(2, 1'b0, 5'd0);
        stepClock();
        stepClock();
        #3;
        rst_n = 1'b1;
        stepClock();
        checkOutput("t6_nostale",   32'(ack),  32'h0);
        checkOutput("t6_idle",      32'(busy), 32'h0);
        applyStimulus(1, 1'b1, 5'd10);
        applyStimulus(3, 1'b1, 5'd11);
        stepClock();
        checkOutput("t6_ptr0_sel",  32'(sel),   32'd10);
        stepClock();
        checkOutput("t6_ack1",      32'(ack),   32'b0010);
        checkOutput("t6_ackid1",    32'(ackId), 32'd1);
        checkOutput("t6_rdata1",    rdData,     32'hAA);
        stepClock();
        checkOutput("t6_ack3",      32'(ack),   32'b1000);
        checkOutput("t6_ackid3",    32'(ackId), 32'd3);
        checkOutput("t6_rdata3",    rdData,     32'hBB);
        applyStimulus(1, 1'b0, 5'd0);
        applyStimulus(3, 1'b0, 5'd0);
        stepClock();
        checkOutput("t6_done",      32'(ack),   32'h0);

        // Round-robin fairness with all four held high
        for (int i = 0; i < 4; i++) begin
            applyStimulus(i, 1'b1, 5'(8 + i));
        end
        stepClock();
        checkOutput("t3_fill", 32'(ack), 32'h0);
        for (int c = 0; c < 12; c++) begin
            checkOutput("t3_wait", 32'(ack), 32'(ack));
            stepClock();
            checkOutput($sformatf("t3_ack%0d", c),   32'(ack),   32'(4'b0001 << (c % 4)));
            checkOutput($sformatf("t3_id%0d", c),    32'(ackId), 32'(c % 4));
            checkOutput($sformatf("t3_data%0d", c),  rdData,     32'((8 + (c % 4)) * 32'h11));
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(i, 1'b0, 5'd0);
        end
        stepClock();
        stepClock();
        stepClock();
        checkOutput("t3_drain_busy", 32'(busy), 32'h0);
        checkOutput("t3_drain_ack",  32'(ack),  32'h0);

        // No double service for a req held through its ack
        begin
            logic [3:0] expAck [9];
            int         ackPulses;
            expAck    = '{4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0010,
                          4'b0000, 4'b0000, 4'b0010, 4'b0000};
            ackPulses = 0;
            applyStimulus(1, 1'b1, 5'd9);
            for (int t = 0; t < 9; t++) begin
                stepClock();
                checkOutput($sformatf("t4_ack%0d", t), 32'(ack), 32'(expAck[t]));
                if (ack[1]) begin
                    ackPulses++;
                    checkOutput($sformatf("t4_data%0d", t), rdData, 32'h99);
                end
            end
            checkOutput("t4_pulses", 32'(ackPulses), 32'd3);
            applyStimulus(1, 1'b0, 5'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
